// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM encodings and line levels.
// Used by the transmitter today and by the receiver later.
package uart_pkg;

    typedef logic [2:0] tx_state_t;

    localparam tx_state_t ST_IDLE   = 3'd0;
    localparam tx_state_t ST_START  = 3'd1;
    localparam tx_state_t ST_DATA   = 3'd2;
    localparam tx_state_t ST_PARITY = 3'd3;
    localparam tx_state_t ST_STOP   = 3'd4;

    localparam logic UART_IDLE_LVL  = 1'b1;
    localparam logic UART_START_LVL = 1'b0;

endpackage

// File: rtl/uart_baud_gen.sv
// Baud tick counter: counts 0..CLKS_PER_BIT-1 while enabled, bit_end_o on the last count.
// Latency: bit_end_o is decoded from the registered count, no input-to-output path.
// Backpressure: none; held at zero while disabled or cleared.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 10416
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic en_i,
    output logic bit_end_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    assign bit_end_o = (count_q == CNT_W'(CLKS_PER_BIT - 1));

    always_comb begin
        count_d = count_q + CNT_W'(1);
        if (clear_i || !en_i || bit_end_o) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_tx_ctrl.sv
// RS232 transmitter: start, DATA_W bits LSB first, optional parity (UART_TX_PARITY_EN), STOP_BITS stops.
// Latency: tx_o leaves idle on the edge that accepts the word; tx_o is a flop.
// Backpressure: tx_ready_o only in IDLE; requests while busy are dropped, not queued.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 10416,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    input  logic              parity_en_i,
    input  logic              parity_odd_i,
    output logic              tx_o,
    output logic              busy_o,
    output logic [2:0]        tx_state_o
);

    localparam int BIT_W = $clog2(DATA_W + 1);

    tx_state_t         state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              tx_q, tx_d;
    logic              accept;
    logic              bit_end;

`ifdef UART_TX_PARITY_EN
    logic par_en_q, par_en_d;
    logic par_bit_q, par_bit_d;
`else
    logic unused_parity_cfg;
    assign unused_parity_cfg = parity_en_i ^ parity_odd_i;
`endif

    assign tx_ready_o = (state_q == ST_IDLE);
    assign busy_o     = (state_q == ST_START) || (state_q == ST_DATA) ||
                        (state_q == ST_PARITY) || (state_q == ST_STOP);
    assign tx_state_o = state_q;
    assign tx_o       = tx_q;
    assign accept     = tx_valid_i && tx_ready_o;

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (accept),
        .en_i      (busy_o),
        .bit_end_o (bit_end)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
`ifdef UART_TX_PARITY_EN
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    shift_d   = tx_data_i;
`ifdef UART_TX_PARITY_EN
                    // Parity is fixed at accept because the shifter destroys the word.
                    par_en_d  = parity_en_i;
                    par_bit_d = (^tx_data_i) ^ parity_odd_i;
`endif
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    if (bit_cnt_q == BIT_W'(DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_d = par_en_q ? ST_PARITY : ST_STOP;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end) begin
                    if (bit_cnt_q == BIT_W'(STOP_BITS - 1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d != state_q) begin
            bit_cnt_d = '0;
        end
    end

    // Line level is decoded from the next state so the pin flop tracks the FSM cycle-exactly.
    always_comb begin
        case (state_d)
            ST_START: tx_d = UART_START_LVL;
            ST_DATA:  tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = par_bit_d;
`endif
            default:  tx_d = UART_IDLE_LVL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= UART_IDLE_LVL;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
`endif
        end
    end

endmodule
